// File: rtl/qed_dup_scheduler.sv
// Phase controller for the QED instruction-duplication cache: alternates original and
// duplicate phases, shadows the duplicate FIFO occupancy and stalls fetch around each switch.
module qed_dup_scheduler #(
  parameter int DEPTH      = 128,
  parameter int BATCH      = 32,
  parameter int IDLE_LIMIT = 64,
  parameter int SETTLE     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       qed_en,
  input  logic                       inst_ren,
  input  logic [63:0]                inst_raddr,
  input  logic [31:0]                instruction_in,
  output logic                       exec_dup,
  output logic                       fetch_hold,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [15:0]                dup_phases,
  output logic                       busy
);

  localparam int OW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(IDLE_LIMIT + 1);
  localparam int SW = $clog2(SETTLE) + 1;

  localparam logic [OW-1:0] OCC_MAX    = OW'(DEPTH - 1);
  localparam logic [OW-1:0] OCC_BATCH  = OW'(BATCH);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_LIMIT);
  localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE - 1);
  localparam logic [31:0]   NOP        = 32'h00000013;
  localparam logic [63:0]   RADDR_INIT = 64'hfffff;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ORIG     = 3'd1,
    SETTLE_O = 3'd2,
    DUP      = 3'd3,
    SETTLE_D = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [OW-1:0] occ_reg, occ_next;
  logic [IW-1:0] idle_reg, idle_next;
  logic [SW-1:0] settle_reg, settle_next;
  logic [63:0]   prev_raddr_reg;
  logic [15:0]   dup_phases_reg;
  logic          exec_dup_reg, fetch_hold_reg;

  logic new_fetch, insert_ev, delete_ev, settle_done, in_settle;

  // Events are qualified by the registered exec_dup, i.e. exactly what the cache sees this cycle.
  always_comb begin
    new_fetch = inst_ren && (inst_raddr != prev_raddr_reg);
    insert_ev = new_fetch && !exec_dup_reg && (instruction_in != NOP) && (occ_reg != OCC_MAX);
    delete_ev = new_fetch && exec_dup_reg && (occ_reg != '0);

    occ_next = occ_reg;
    if (insert_ev)
      occ_next = occ_reg + OW'(1);
    else if (delete_ev)
      occ_next = occ_reg - OW'(1);

    idle_next = idle_reg;
    if (insert_ev || occ_reg == '0)
      idle_next = '0;
    else if (idle_reg != IDLE_MAX)
      idle_next = idle_reg + IW'(1);
  end

  always_comb begin
    state_next  = state_reg;
    in_settle   = (state_reg == SETTLE_O) || (state_reg == SETTLE_D);
    settle_done = in_settle && (settle_reg == SETTLE_END);

    case (state_reg)
      IDLE: begin
        if (qed_en)
          state_next = ORIG;
      end
      ORIG: begin
        if (!qed_en && occ_reg == '0)
          state_next = IDLE;
        else if ((occ_next >= OCC_BATCH) ||
                 (idle_reg == IDLE_MAX && occ_reg != '0) ||
                 (!qed_en && occ_reg != '0))
          state_next = SETTLE_O;
      end
      SETTLE_O: begin
        if (settle_done)
          state_next = DUP;
      end
      DUP: begin
        if (occ_next == '0)
          state_next = SETTLE_D;
      end
      SETTLE_D: begin
        if (settle_done)
          state_next = qed_en ? ORIG : IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Counter idles at 0 outside settle windows, so every window starts from 0.
    settle_next = (in_settle && !settle_done) ? settle_reg + SW'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      occ_reg        <= '0;
      idle_reg       <= '0;
      settle_reg     <= '0;
      prev_raddr_reg <= RADDR_INIT;
      dup_phases_reg <= '0;
      exec_dup_reg   <= 1'b0;
      fetch_hold_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      occ_reg        <= occ_next;
      idle_reg       <= idle_next;
      settle_reg     <= settle_next;
      if (inst_ren)
        prev_raddr_reg <= inst_raddr;
      if (state_reg == DUP && state_next == SETTLE_D && dup_phases_reg != 16'hFFFF)
        dup_phases_reg <= dup_phases_reg + 16'd1;
      exec_dup_reg   <= (state_next == DUP);
      fetch_hold_reg <= (state_next == SETTLE_O) || (state_next == SETTLE_D);
    end
  end

  assign exec_dup   = exec_dup_reg;
  assign fetch_hold = fetch_hold_reg;
  assign occupancy  = occ_reg;
  assign dup_phases = dup_phases_reg;
  assign busy       = (state_reg != IDLE);

endmodule
